// File: rtl/iob2axi_burst_ctrl.sv
// IOB-to-AXI burst controller: splits one transfer into AXI bursts that never
// cross a 4 KB page or exceed 2^AXI_LEN_W beats, launching one engine burst at a time.
module iob2axi_burst_ctrl #(
  parameter int AXI_ADDR_W = 32,
  parameter int DATA_W     = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int NWORDS_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dir,
  input  logic [AXI_ADDR_W-1:0] addr,
  input  logic [NWORDS_W-1:0]   nwords,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  eng_run_rd,
  output logic                  eng_run_wr,
  output logic [AXI_ADDR_W-1:0] eng_addr,
  output logic [AXI_LEN_W-1:0]  eng_len,
  input  logic                  eng_ready,
  input  logic                  eng_error
);

  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int MAX_W   = (NWORDS_W > AXI_LEN_W) ? NWORDS_W : AXI_LEN_W;
  // Wide enough for the beat count, 2^AXI_LEN_W and a whole 4 KB page of beats
  localparam int CNT_W   = ((MAX_W > 13) ? MAX_W : 13) + 1;
  localparam logic [CNT_W-1:0] MAX_BEATS = CNT_W'(1) << AXI_LEN_W;

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [AXI_ADDR_W-1:0] curAddr_q, curAddr_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic [CNT_W-1:0]      burst_q, burst_d;
  logic                  dir_q, dir_d;
  logic                  error_q, error_d;
  logic                  waitFirst_q, waitFirst_d;
  logic [AXI_ADDR_W-1:0] engAddr_q, engAddr_d;
  logic [AXI_LEN_W-1:0]  engLen_q, engLen_d;

  logic [12:0]           pageBytes;
  logic [CNT_W-1:0]      pageBeats;
  logic [CNT_W-1:0]      burstMin;
  logic [CNT_W-1:0]      remLeft;

  always_comb begin
    pageBytes = 13'h1000 - {1'b0, curAddr_q[11:0]};
    pageBeats = CNT_W'(pageBytes >> BYTE_SH);
    burstMin  = remaining_q;
    if (MAX_BEATS < burstMin) burstMin = MAX_BEATS;
    if (pageBeats < burstMin) burstMin = pageBeats;
  end

  always_comb begin
    state_d     = state_q;
    curAddr_d   = curAddr_q;
    remaining_d = remaining_q;
    burst_d     = burst_q;
    dir_d       = dir_q;
    error_d     = error_q;
    waitFirst_d = waitFirst_q;
    engAddr_d   = engAddr_q;
    engLen_d    = engLen_q;
    remLeft     = remaining_q - burst_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          curAddr_d   = addr;
          remaining_d = CNT_W'(nwords);
          dir_d       = dir;
          error_d     = 1'b0;
          state_d     = (nwords == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        burst_d   = burstMin;
        engAddr_d = curAddr_q;
        engLen_d  = AXI_LEN_W'(burstMin - CNT_W'(1));
        state_d   = ISSUE;
      end
      ISSUE: begin
        waitFirst_d = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        waitFirst_d = 1'b0;
        if (eng_error) error_d = 1'b1;
        // The engine may still show ready on the cycle right after launch
        if (!waitFirst_q && eng_ready) begin
          curAddr_d   = curAddr_q + AXI_ADDR_W'(burst_q << BYTE_SH);
          remaining_d = remLeft;
          state_d     = (remLeft == '0 || error_q || eng_error) ? DONE : CALC;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      curAddr_q   <= '0;
      remaining_q <= '0;
      burst_q     <= '0;
      dir_q       <= 1'b0;
      error_q     <= 1'b0;
      waitFirst_q <= 1'b0;
      engAddr_q   <= '0;
      engLen_q    <= '0;
    end else begin
      state_q     <= state_d;
      curAddr_q   <= curAddr_d;
      remaining_q <= remaining_d;
      burst_q     <= burst_d;
      dir_q       <= dir_d;
      error_q     <= error_d;
      waitFirst_q <= waitFirst_d;
      engAddr_q   <= engAddr_d;
      engLen_q    <= engLen_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign error      = error_q;
  assign eng_run_rd = (state_q == ISSUE) && !dir_q;
  assign eng_run_wr = (state_q == ISSUE) && dir_q;
  assign eng_addr   = engAddr_q;
  assign eng_len    = engLen_q;

endmodule

// File: tb/tb_iob2axi_burst_ctrl.sv
// Self-checking bench for iob2axi_burst_ctrl: a burst-list model predicts every
// engine launch, plus literal expectations for the directed scenarios.
module tb_iob2axi_burst_ctrl;

  localparam int AW = 32;
  localparam int LW = 8;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [NW-1:0] nwords = '0;
  logic          busy, done, error, eng_run_rd, eng_run_wr;
  logic [AW-1:0] eng_addr;
  logic [LW-1:0] eng_len;
  logic          eng_ready = 1'b1;
  logic          eng_error = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int engDelay = 3;
  int errBurst = -1;
  int engCnt = 0;
  int runIdx = 0;

  int     obsCount = 0;
  int     doneCount = 0;
  int     firstRunCyc = 0;
  int     doneCyc = 0;
  longint obsAddr[64];
  longint obsLen[64];
  logic   obsWr[64];

  int startCyc = 0;
  int obsBase = 0;
  int doneBase = 0;

  longint expAddrQ[$];
  longint expLenQ[$];
  logic   modelBusy = 1'b0;
  logic   modelDir = 1'b0;
  logic   expErr = 1'b0;
  logic   heldErr = 1'b0;
  logic   haveIssued = 1'b0;
  longint lastAddr = 0;
  longint lastLen = 0;
  longint mA, mB, mPg, mRem, ea, el;
  int     mK;

  iob2axi_burst_ctrl #(
    .AXI_ADDR_W(AW),
    .DATA_W    (32),
    .AXI_LEN_W (LW),
    .NWORDS_W  (NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir       (dir),
    .addr      (addr),
    .nwords    (nwords),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .eng_run_rd(eng_run_rd),
    .eng_run_wr(eng_run_wr),
    .eng_addr  (eng_addr),
    .eng_len   (eng_len),
    .eng_ready (eng_ready),
    .eng_error (eng_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine stand-in: drops ready for engDelay cycles after each launch and
  // raises eng_error for the whole of burst number errBurst
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      engCnt = 0;
      runIdx = 0;
      eng_ready = 1'b1;
      eng_error = 1'b0;
    end else if (eng_run_rd || eng_run_wr) begin
      eng_error = (runIdx == errBurst);
      runIdx++;
      engCnt = engDelay;
      eng_ready = (engDelay == 0);
    end else begin
      if (!busy) runIdx = 0;
      if (engCnt > 0) engCnt--;
      if (engCnt == 0) begin
        eng_ready = 1'b1;
        eng_error = 1'b0;
      end
    end
  end

  // Compare process: the model turns each accepted request into the list of
  // bursts it must produce, then every cycle is checked against that list
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("reset_outputs", {busy, done, error, eng_run_rd, eng_run_wr, eng_addr, eng_len}, 64'd0);
      modelBusy = 1'b0;
      heldErr = 1'b0;
      haveIssued = 1'b0;
      expAddrQ.delete();
      expLenQ.delete();
    end else begin
      checkOutput("busy", busy, modelBusy);
      checkOutput("run_exclusive", eng_run_rd & eng_run_wr, 64'd0);
      if (eng_run_rd || eng_run_wr) begin
        if (expAddrQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_run: got run at 0x%0h, expected no run (cycle %0d)", eng_addr, cyc);
        end else begin
          ea = expAddrQ.pop_front();
          el = expLenQ.pop_front();
          checkOutput("run_addr", eng_addr, ea);
          checkOutput("run_len", eng_len, el);
          checkOutput("run_dir", eng_run_wr, modelDir);
          lastAddr = ea;
          lastLen = el;
        end
        if (!haveIssued) firstRunCyc = cyc;
        haveIssued = 1'b1;
        if (obsCount < 64) begin
          obsAddr[obsCount] = eng_addr;
          obsLen[obsCount] = eng_len;
          obsWr[obsCount] = eng_run_wr;
        end
        obsCount++;
      end else if (modelBusy && haveIssued) begin
        checkOutput("eng_addr_hold", eng_addr, lastAddr);
        checkOutput("eng_len_hold", eng_len, lastLen);
      end
      if (done) begin
        if (!modelBusy) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious_done: got done=1, expected 0 (cycle %0d)", cyc);
        end else begin
          checkOutput("bursts_left", expAddrQ.size(), 64'd0);
          checkOutput("done_error", error, expErr);
        end
        doneCount++;
        doneCyc = cyc;
        heldErr = expErr;
        modelBusy = 1'b0;
        haveIssued = 1'b0;
      end else if (!modelBusy) begin
        checkOutput("error_held", error, heldErr);
        if (start) begin
          mA = addr;
          mRem = nwords;
          mK = 0;
          modelDir = dir;
          expErr = 1'b0;
          expAddrQ.delete();
          expLenQ.delete();
          while (mRem > 0) begin
            mB = (mRem < 256) ? mRem : 256;
            mPg = (4096 - (mA % 4096)) / 4;
            if (mPg < mB) mB = mPg;
            expAddrQ.push_back(mA);
            expLenQ.push_back(mB - 1);
            mA = (mA + mB * 4) % 64'h1_0000_0000;
            mRem = mRem - mB;
            if (mK == errBurst) begin
              expErr = 1'b1;
              mRem = 0;
            end
            mK++;
          end
          modelBusy = 1'b1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input int n, input logic d,
                               input int eb, input int dly, input bit waitForDone);
    int k;
    @(posedge clk);
    #1;
    engDelay = dly;
    errBurst = eb;
    addr = a;
    nwords = n[15:0];
    dir = d;
    start = 1'b1;
    startCyc = cyc;
    obsBase = obsCount;
    doneBase = doneCount;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (waitForDone) begin
      k = 0;
      while (doneCount == doneBase && k < 4000) begin
        @(posedge clk);
        k++;
      end
      if (doneCount == doneBase) begin
        checks++;
        errors++;
        $display("[TB] FAIL done_timeout: got no done in %0d cycles, expected a done pulse", k);
      end
    end
  endtask

  initial begin
    int k;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Single 16-beat read from address 0
    applyStimulus(32'h0, 16, 1'b0, -1, 3, 1'b1);
    checkOutput("t1_runs", obsCount - obsBase, 64'd1);
    checkOutput("t1_addr", obsAddr[obsBase], 64'h0);
    checkOutput("t1_len", obsLen[obsBase], 64'd15);
    checkOutput("t1_is_read", obsWr[obsBase], 64'd0);
    checkOutput("t1_latency", firstRunCyc - startCyc, 64'd2);

    // Write that straddles a 4 KB page
    applyStimulus(32'hFF0, 8, 1'b1, -1, 2, 1'b1);
    checkOutput("t2_runs", obsCount - obsBase, 64'd2);
    checkOutput("t2_addr0", obsAddr[obsBase], 64'hFF0);
    checkOutput("t2_len0", obsLen[obsBase], 64'd3);
    checkOutput("t2_addr1", obsAddr[obsBase+1], 64'h1000);
    checkOutput("t2_len1", obsLen[obsBase+1], 64'd3);
    checkOutput("t2_is_write", obsWr[obsBase+1], 64'd1);

    // Long read split by the burst-length limit
    applyStimulus(32'h0, 600, 1'b0, -1, 1, 1'b1);
    checkOutput("t3_runs", obsCount - obsBase, 64'd3);
    checkOutput("t3_addr0", obsAddr[obsBase], 64'h0);
    checkOutput("t3_len0", obsLen[obsBase], 64'd255);
    checkOutput("t3_addr1", obsAddr[obsBase+1], 64'h400);
    checkOutput("t3_len1", obsLen[obsBase+1], 64'd255);
    checkOutput("t3_addr2", obsAddr[obsBase+2], 64'h800);
    checkOutput("t3_len2", obsLen[obsBase+2], 64'd87);

    // Zero-length request completes at once
    applyStimulus(32'h40, 0, 1'b0, -1, 3, 1'b1);
    checkOutput("t4_runs", obsCount - obsBase, 64'd0);
    checkOutput("t4_done_latency", doneCyc - startCyc, 64'd1);
    checkOutput("t4_error", error, 64'd0);

    // Engine error on the first of three bursts stops the transfer
    applyStimulus(32'h0, 600, 1'b0, 0, 3, 1'b1);
    checkOutput("t5_runs", obsCount - obsBase, 64'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t5_error_held", error, 64'd1);

    // Next start clears the error; engine shows ready straight after launch
    applyStimulus(32'h100, 4, 1'b1, -1, 0, 1'b1);
    checkOutput("t6_error_cleared", error, 64'd0);
    checkOutput("t6_runs", obsCount - obsBase, 64'd1);
    checkOutput("t6_addr", obsAddr[obsBase], 64'h100);
    checkOutput("t6_len", obsLen[obsBase], 64'd3);

    // Address wraps past the top of the address space
    applyStimulus(32'hFFFF_FFF8, 4, 1'b0, -1, 2, 1'b1);
    checkOutput("t7_runs", obsCount - obsBase, 64'd2);
    checkOutput("t7_addr0", obsAddr[obsBase], 64'hFFFF_FFF8);
    checkOutput("t7_len0", obsLen[obsBase], 64'd1);
    checkOutput("t7_addr1", obsAddr[obsBase+1], 64'h0);
    checkOutput("t7_len1", obsLen[obsBase+1], 64'd1);

    // Reset while the engine is busy aborts without a done pulse
    applyStimulus(32'h2000, 16, 1'b0, -1, 10, 1'b0);
    k = 0;
    while (obsCount == obsBase && k < 20) begin
      @(posedge clk);
      k++;
    end
    checkOutput("t8_launched", obsCount - obsBase, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("t8_abort_outputs", {busy, done, error, eng_run_rd, eng_run_wr, eng_addr, eng_len}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    checkOutput("t8_no_done", doneCount - doneBase, 64'd0);

    applyStimulus(32'h3000, 16, 1'b1, -1, 2, 1'b1);
    checkOutput("t9_runs", obsCount - obsBase, 64'd1);
    checkOutput("t9_addr", obsAddr[obsBase], 64'h3000);
    checkOutput("t9_len", obsLen[obsBase], 64'd15);
    checkOutput("t9_is_write", obsWr[obsBase], 64'd1);
    checkOutput("t9_latency", firstRunCyc - startCyc, 64'd2);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion within 20000 cycles");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/iob2axi_burst_ctrl.md
IOB2AXI_BURST_CTRL -- requirements
Module: iob2axi_burst_ctrl

Interface
REQ-001 SHALL have parameter AXI_ADDR_W, default 32, AXI byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data beat width in bits (power of 2, 8..1024).
REQ-003 SHALL have parameter AXI_LEN_W, default 8, AXI burst-length field width.
REQ-004 SHALL have parameter NWORDS_W, default 16, transfer-length width in beats.
REQ-005 SHALL have ports: clk  in  1  clock, single clock domain, all logic on rising edge.
REQ-006 SHALL have: rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have: start  in  1  one-cycle transfer request, sampled only in IDLE.
REQ-008 SHALL have: dir  in  1  0 = read, 1 = write.
REQ-009 SHALL have: addr  in  AXI_ADDR_W  first byte address, aligned to DATA_W/8.
REQ-010 SHALL have: nwords  in  NWORDS_W  total beats to transfer.
REQ-011 SHALL have: busy  out  1  high from the cycle after accepted start until the cycle done is high, inclusive.
REQ-012 SHALL have: done  out  1  one-cycle completion pulse.
REQ-013 SHALL have: error  out  1  sticky engine error for the current or last transfer.
REQ-014 SHALL have: eng_run_rd, eng_run_wr  out  1 each  one-cycle burst-launch pulses to the read/write engines.
REQ-015 SHALL have: eng_addr  out  AXI_ADDR_W  burst start address.
REQ-016 SHALL have: eng_len  out  AXI_LEN_W  burst length minus 1 (AXI encoding).
REQ-017 SHALL have: eng_ready  in  1  selected engine idle.
REQ-018 SHALL have: eng_error  in  1  selected engine error flag.

Function
REQ-019 SHALL implement FSM states IDLE, CALC, ISSUE, WAIT, DONE.
REQ-020 IDLE: on start=1, SHALL latch addr, nwords, and dir into internal registers and go to CALC; if nwords=0, SHALL go directly to DONE.
REQ-021 CALC: SHALL compute burst = min(remaining, 2^AXI_LEN_W, (4096 - cur_addr[11:0]) / (DATA_W/8)) and register it; next state ISSUE.
REQ-022 ISSUE: SHALL hold eng_run_rd (dir=0) or eng_run_wr (dir=1) high for exactly one cycle, with eng_addr=cur_addr and eng_len=burst-1 valid in the same cycle; next state WAIT.
REQ-023 eng_addr and eng_len SHALL remain stable from ISSUE until the next ISSUE or IDLE.
REQ-024 WAIT: SHALL ignore eng_ready on the first cycle after ISSUE, then wait for eng_ready=1.
REQ-025 On leaving WAIT, SHALL update cur_addr += burst*(DATA_W/8) and remaining -= burst.
REQ-026 On leaving WAIT, SHALL go to DONE if the new remaining is 0 or error=1, else to CALC.
REQ-027 DONE: SHALL pulse done for one cycle; next state IDLE.
REQ-028 No burst SHALL cross a 4 KB boundary or exceed 2^AXI_LEN_W beats.
REQ-029 Latency: start accepted in cycle T SHALL yield the first eng_run in cycle T+2; nwords=0 SHALL yield done in cycle T+1 with no eng_run.
REQ-030 start outside IDLE SHALL be ignored.
REQ-031 The error flag SHALL be cleared on an accepted start.
REQ-032 The error flag SHALL be set when eng_error=1 in WAIT; the current burst SHALL complete and no further bursts SHALL be issued.
REQ-033 Address arithmetic SHALL be modulo 2^AXI_ADDR_W.
REQ-034 Burst arithmetic SHALL be performed at NWORDS_W+1 bits to avoid truncation when 2^AXI_LEN_W > remaining.
REQ-035 eng_run_rd and eng_run_wr SHALL never be high simultaneously.

Reset
REQ-036 While rst=0, SHALL force state IDLE, and busy, done, error, eng_run_rd, eng_run_wr, eng_addr, eng_len, and all internal counters to 0.
REQ-037 Reset asserted mid-transfer SHALL abort immediately with no done pulse; the first start after release SHALL behave as from power-up.

Verification (DATA_W=32, AXI_LEN_W=8)
REQ-038 SHALL test: start, dir=0, addr=0x0, nwords=16 -> single eng_run_rd at T+2 with eng_addr=0x0, eng_len=15; done after eng_ready returns.
REQ-039 SHALL test: addr=0xFF0, nwords=8, dir=1 -> two eng_run_wr: 0xFF0/len 3, then 0x1000/len 3; one done.
REQ-040 SHALL test: addr=0x0, nwords=600 -> bursts 0x000/len 255, 0x400/len 255, 0x800/len 87.
REQ-041 SHALL test: nwords=0 -> done at T+1, no eng_run, error=0.
REQ-042 SHALL test: eng_error=1 during the first of three bursts -> no second eng_run, done pulses, error=1 held until next start.
REQ-043 SHALL test: rst=0 during WAIT -> all outputs 0 immediately, no done; a new start then runs normally.
